// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and helpers for the memory stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t ST_IDLE   = 2'd0;
  localparam mem_state_t ST_ACCESS = 2'd1;
  localparam mem_state_t ST_HALTED = 2'd2;

  typedef struct packed {
    logic acc;          // instruction touches data memory
    logic we;           // write rather than read
    logic addr_from_a;  // address comes from valA (ret/popq) instead of valE
  } mem_class_t;

  function automatic mem_class_t classify(input logic [3:0] icode);
    mem_class_t c;
    c = '{acc: 1'b0, we: 1'b0, addr_from_a: 1'b0};
    case (icode)
      IRMMOVQ, ICALL, IPUSHQ: c = '{acc: 1'b1, we: 1'b1, addr_from_a: 1'b0};
      IMRMOVQ:                c = '{acc: 1'b1, we: 1'b0, addr_from_a: 1'b0};
      IRET, IPOPQ:            c = '{acc: 1'b1, we: 1'b0, addr_from_a: 1'b1};
      default:                ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit wait counter for an outstanding data-memory request.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic reached
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count_reg <= '0;
    end else if (enable && !reached) begin
      count_reg <= count_reg + 8'd1;
    end
  end

  // Asserted in the cycle whose increment brings the count to TIMEOUT,
  // so the owner can react on that same edge.
  assign reached = enable && (count_reg == LAST);

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: one instruction in flight, variable-latency dmem access,
// registered writeback result, freezes after the first non-AOK outcome.
module memory_stage
  import y86_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = 8192,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [2:0]  ex_stat,
  input  logic [3:0]  ex_icode,
  input  logic [63:0] ex_valE,
  input  logic [63:0] ex_valA,
  input  logic [3:0]  ex_dstE,
  input  logic [3:0]  ex_dstM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic [2:0]  wb_stat,
  output logic [3:0]  wb_icode,
  output logic [63:0] wb_valE,
  output logic [63:0] wb_valM,
  output logic [3:0]  wb_dstE,
  output logic [3:0]  wb_dstM,
  output logic        halted
);

  mem_state_t  state_reg;
  logic        we_reg;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic        wb_valid_reg;
  logic [2:0]  wb_stat_reg;
  logic [3:0]  wb_icode_reg;
  logic [63:0] wb_valE_reg;
  logic [63:0] wb_valM_reg;
  logic [3:0]  wb_dstE_reg;
  logic [3:0]  wb_dstM_reg;

  mem_class_t  cls;
  logic [63:0] req_addr;
  logic [64:0] addr_end;
  logic        addr_bad;
  logic        in_access;
  logic        timed_out;

  assign cls       = classify(ex_icode);
  assign req_addr  = cls.addr_from_a ? ex_valA : ex_valE;
  // 65-bit sum so an address near 2^64 cannot wrap into the legal range.
  assign addr_end  = {1'b0, req_addr} + 65'd8;
  assign addr_bad  = addr_end > 65'(DMEM_BYTES);
  assign in_access = (state_reg == ST_ACCESS);

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_access),
    .enable (in_access && !dmem_ack),
    .reached(timed_out)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wb_valid_reg <= 1'b0;
      wb_stat_reg  <= SAOK;
      wb_icode_reg <= IHALT;
      wb_valE_reg  <= '0;
      wb_valM_reg  <= '0;
      wb_dstE_reg  <= RNONE;
      wb_dstM_reg  <= RNONE;
    end else begin
      wb_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (ex_valid) begin
            wb_icode_reg <= ex_icode;
            wb_valE_reg  <= ex_valE;
            wb_valM_reg  <= '0;
            wb_dstE_reg  <= ex_dstE;
            wb_dstM_reg  <= ex_dstM;
            if (ex_stat != SAOK) begin
              wb_valid_reg <= 1'b1;
              wb_stat_reg  <= ex_stat;
              state_reg    <= ST_HALTED;
            end else if (!cls.acc) begin
              wb_valid_reg <= 1'b1;
              if (ex_icode == IHALT) begin
                wb_stat_reg <= SHLT;
                state_reg   <= ST_HALTED;
              end else begin
                wb_stat_reg <= SAOK;
              end
            end else if (addr_bad) begin
              wb_valid_reg <= 1'b1;
              wb_stat_reg  <= SADR;
              state_reg    <= ST_HALTED;
            end else begin
              we_reg    <= cls.we;
              addr_reg  <= req_addr;
              wdata_reg <= ex_valA;
              state_reg <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // An ack in the expiry cycle still completes the access normally.
          if (dmem_ack) begin
            wb_valid_reg <= 1'b1;
            wb_stat_reg  <= SAOK;
            if (!we_reg) begin
              wb_valM_reg <= dmem_rdata;
            end
            state_reg <= ST_IDLE;
          end else if (timed_out) begin
            wb_valid_reg <= 1'b1;
            wb_stat_reg  <= SADR;
            state_reg    <= ST_HALTED;
          end
        end
        default: begin
          state_reg <= ST_HALTED;
        end
      endcase
    end
  end

  assign ex_ready   = (state_reg == ST_IDLE);
  assign halted     = (state_reg == ST_HALTED);
  assign dmem_req   = in_access;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign wb_valid   = wb_valid_reg;
  assign wb_stat    = wb_stat_reg;
  assign wb_icode   = wb_icode_reg;
  assign wb_valE    = wb_valE_reg;
  assign wb_valM    = wb_valM_reg;
  assign wb_dstE    = wb_dstE_reg;
  assign wb_dstM    = wb_dstM_reg;

endmodule
